// File: rtl/aes192_ks_pkg.sv
// Shared types and sizes for the AES-192 key schedule controller.
// Round-key table geometry and the controller state encoding.
package aes192_ks_pkg;

  localparam int NUM_RK   = 13;
  localparam int RK_W     = 128;
  localparam int KEY_W    = 192;
  localparam int RK_IDX_W = 4;

  localparam logic [RK_IDX_W-1:0] LAST_IDX =
    RK_IDX_W'(NUM_RK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    COLLECT
  } ks_state_e;

endpackage

// File: rtl/aes192_rk_regfile.sv
// 13x128 round-key table: one write port, one registered read port.
// Out-of-range reads return zero; async clear empties the table.
module aes192_rk_regfile
  import aes192_ks_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [RK_IDX_W-1:0] wr_idx,
  input  logic [RK_W-1:0]     wr_data,
  input  logic [RK_IDX_W-1:0] rd_idx,
  output logic [RK_W-1:0]     rd_data
);

  logic [RK_W-1:0] mem [NUM_RK];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_RK; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (we && wr_idx <= LAST_IDX) begin
        mem[wr_idx] <= wr_data;
      end
      // same-edge read of a written index sees the old entry
      rd_data <= (rd_idx <= LAST_IDX) ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/aes192_key_sched_ctrl.sv
// AES-192 key expander sequencer and round-key server.
// Define AES192_KS_REUSE_EN to skip re-expansion of an unchanged key.
module aes192_key_sched_ctrl
  import aes192_ks_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_req_valid,
  output logic                key_req_ready,
  input  logic [KEY_W-1:0]    key_in,
  output logic                ks_start,
  output logic [KEY_W-1:0]    ks_key,
  input  logic [RK_W-1:0]     ks_subkey,
  input  logic [RK_IDX_W-1:0] ks_cnt,
  input  logic                ks_valid,
  input  logic [RK_IDX_W-1:0] rk_rd_idx,
  output logic [RK_W-1:0]     rk_rd_data,
  output logic                keys_ready,
  output logic                busy,
  output logic                ks_err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  ks_state_e           state;
  ks_state_e           state_nx;
  logic [RK_IDX_W-1:0] exp_idx;
  logic [TW-1:0]       to_cnt;

  logic                accept;
  logic                reuse;
  logic                start_run;
  logic                in_col;
  logic                capture;
  logic                bad_cnt;
  logic                timeout;
  logic                last;

  logic                rf_we;
  logic [RK_IDX_W-1:0] rf_idx;
  logic [RK_W-1:0]     rf_data;

  assign accept = (state == IDLE) && key_req_valid;

`ifdef AES192_KS_REUSE_EN
  assign reuse = keys_ready && (key_in == ks_key);
`else
  assign reuse = 1'b0;
`endif

  assign start_run = accept && !reuse;
  assign in_col    = (state == COLLECT);
  assign capture   = in_col && ks_valid && (ks_cnt == exp_idx);
  assign bad_cnt   = in_col && ks_valid && (ks_cnt != exp_idx);
  assign timeout   = in_col && !ks_valid && (to_cnt == TO_LAST);
  assign last      = capture && (exp_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    key_req_ready = 1'b0;
    ks_start      = 1'b0;
    busy          = 1'b0;
    unique case (state)
      IDLE: begin
        key_req_ready = 1'b1;
        if (start_run) begin
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        ks_start = 1'b1;
        busy     = 1'b1;
        state_nx = COLLECT;
      end
      COLLECT: begin
        busy = 1'b1;
        if (last || bad_cnt || timeout) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ks_key     <= '0;
      exp_idx    <= '0;
      to_cnt     <= '0;
      keys_ready <= 1'b0;
      ks_err     <= 1'b0;
    end else begin
      if (start_run) begin
        ks_key     <= key_in;
        exp_idx    <= RK_IDX_W'(1);
        to_cnt     <= '0;
        keys_ready <= 1'b0;
        ks_err     <= 1'b0;
      end
      if (capture) begin
        exp_idx <= exp_idx + RK_IDX_W'(1);
        to_cnt  <= '0;
        if (exp_idx == LAST_IDX) begin
          keys_ready <= 1'b1;
        end
      end else if (in_col && !ks_valid) begin
        to_cnt <= to_cnt + TW'(1);
      end
      if (bad_cnt || timeout) begin
        ks_err <= 1'b1;
      end
    end
  end

  // round key 0 comes straight from the accepted cipher key
  assign rf_we   = start_run || capture;
  assign rf_idx  = start_run ? '0 : exp_idx;
  assign rf_data = start_run ? key_in[KEY_W-1 -: RK_W] : ks_subkey;

  aes192_rk_regfile u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .wr_idx  (rf_idx),
    .wr_data (rf_data),
    .rd_idx  (rk_rd_idx),
    .rd_data (rk_rd_data)
  );

endmodule

// File: tb/tb_aes192_key_sched_ctrl.sv
// Bench for aes192_key_sched_ctrl: stub expander partner plus
// a read-port scoreboard checked against a FIPS-197 key expansion.
module tb_aes192_key_sched_ctrl;

  logic         clk;
  logic         reset;
  logic         key_req_valid;
  logic         key_req_ready;
  logic [191:0] key_in;
  logic         ks_start;
  logic [191:0] ks_key;
  logic [127:0] ks_subkey;
  logic [3:0]   ks_cnt;
  logic         ks_valid;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         keys_ready;
  logic         busy;
  logic         ks_err;

  int n_chk;
  int n_fail;
  int start_cnt;
  int stub_mode;
  logic rd_issue;
  logic rd_d;
  logic [127:0] exp_q [$];
  logic [3:0]   idx_q [$];

  localparam logic [191:0] K =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] KF =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  aes192_key_sched_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .key_req_valid (key_req_valid),
    .key_req_ready (key_req_ready),
    .key_in        (key_in),
    .ks_start      (ks_start),
    .ks_key        (ks_key),
    .ks_subkey     (ks_subkey),
    .ks_cnt        (ks_cnt),
    .ks_valid      (ks_valid),
    .rk_rd_idx     (rk_rd_idx),
    .rk_rd_data    (rk_rd_data),
    .keys_ready    (keys_ready),
    .busy          (busy),
    .ks_err        (ks_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse then affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [12:0][127:0] expand(input logic [191:0] k);
    logic [31:0] w [52];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [12:0][127:0] r;
    for (int i = 0; i < 6; i++) w[i] = k[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = w[i-1];
      if (i % 6 == 0) begin
        rc = 8'h01 << (i/6 - 1);
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]),
             sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
      end
      w[i] = w[i-6] ^ t;
    end
    for (int j = 0; j < 13; j++)
      r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  function automatic logic [191:0] rand_key();
    return {$urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom};
  endfunction

  task automatic tally(input string nm, input bit ok,
                       input string act, input string exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic a, input logic e);
    tally(nm, a === e, $sformatf("%b", a), $sformatf("%b", e));
  endtask

  task automatic chki(input string nm, input int a, input int e);
    tally(nm, a == e, $sformatf("%0d", a), $sformatf("%0d", e));
  endtask

  task automatic chkd(input string nm, input logic [127:0] a,
                      input logic [127:0] e);
    tally(nm, a === e, $sformatf("%h", a), $sformatf("%h", e));
  endtask

  task automatic chkk(input string nm, input logic [191:0] a,
                      input logic [191:0] e);
    tally(nm, a === e, $sformatf("%h", a), $sformatf("%h", e));
  endtask

  // expander partner: emits rk1..rk12 starting the cycle after start
  always begin : stub
    logic [12:0][127:0] srk;
    @(posedge clk);
    if (ks_start === 1'b1) begin
      srk = expand(ks_key);
      #1;
      for (int n = 1; n <= 12; n++) begin
        if (stub_mode == 2 && n == 5) begin
          ks_valid = 1'b0;
          repeat (4) @(posedge clk);
          #1;
        end
        ks_valid  = 1'b1;
        ks_cnt    = (stub_mode == 1 && n == 2) ? 4'd3 : 4'(n);
        ks_subkey = srk[n];
        @(posedge clk);
        #1;
      end
      ks_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (ks_start === 1'b1) start_cnt++;
    rd_d <= rd_issue;
  end

  always @(negedge clk) begin
    if (rd_d === 1'b1) begin
      if (exp_q.size() == 0) begin
        tally("rd_unexpected", 1'b0, "data", "none");
      end else begin
        chkd($sformatf("rd_idx%0d", idx_q.pop_front()),
             rk_rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [3:0] idx, input logic [127:0] e);
    @(negedge clk);
    rk_rd_idx = idx;
    idx_q.push_back(idx);
    exp_q.push_back(e);
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic check_table(input logic [191:0] k);
    logic [12:0][127:0] r;
    r = expand(k);
    for (int i = 0; i < 13; i++) rd(4'(i), r[i]);
    rd(4'd13, 128'd0);
    rd(4'd15, 128'd0);
  endtask

  task automatic request(input string nm, input logic [191:0] k,
                         input int exp_cyc, input logic exp_start);
    int cyc;
    int s0;
    @(negedge clk);
    key_in = k;
    key_req_valid = 1'b1;
    cyc = 0;
    while (key_req_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chkb({nm, "_ready"}, key_req_ready, 1'b1);
    s0 = start_cnt;
    @(posedge clk);
    #1 key_req_valid = 1'b0;
    @(negedge clk);
    chkb({nm, "_start"}, ks_start, exp_start);
    chkb({nm, "_busy"}, busy, exp_start);
    chkb({nm, "_errclr"}, ks_err, 1'b0);
    cyc = 0;
    while (!(keys_ready === 1'b1 && busy === 1'b0)
           && ks_err !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chki({nm, "_cycles"}, cyc, exp_cyc);
    chki({nm, "_npulse"}, start_cnt - s0, int'(exp_start));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [191:0] k2;
    n_chk = 0;
    n_fail = 0;
    start_cnt = 0;
    stub_mode = 0;
    rd_issue = 1'b0;
    reset = 1'b0;
    key_req_valid = 1'b0;
    key_in = '0;
    ks_subkey = '0;
    ks_cnt = '0;
    ks_valid = 1'b0;
    rk_rd_idx = '0;
    #3;
    chkb("rst_ready", key_req_ready, 1'b1);
    chkb("rst_start", ks_start, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_kr", keys_ready, 1'b0);
    chkb("rst_err", ks_err, 1'b0);
    chkk("rst_kskey", ks_key, 192'd0);
    chkd("rst_rd", rk_rd_data, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    request("t1", K, 13, 1'b1);
    chkk("t1_kskey", ks_key, K);
    rd(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    check_table(K);

    request("t2", KF, 13, 1'b1);
    rd(4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd(4'd12, 128'he98ba06f448c773c8ecc720401002202);
    check_table(KF);

    stub_mode = 1;
    request("t3", K, 3, 1'b1);
    chkb("t3_err", ks_err, 1'b1);
    chkb("t3_kr", keys_ready, 1'b0);
    chkb("t3_ready", key_req_ready, 1'b1);
    repeat (20) @(negedge clk);
    chkb("t3_sticky", ks_err, 1'b1);
    stub_mode = 0;

    stub_mode = 2;
    request("t4", K, 9, 1'b1);
    chkb("t4_err", ks_err, 1'b1);
    chkb("t4_busy", busy, 1'b0);
    chkb("t4_ready", key_req_ready, 1'b1);
    repeat (20) @(negedge clk);
    stub_mode = 0;
    k2 = rand_key();
    request("t4b", k2, 13, 1'b1);
    chkb("t4b_err", ks_err, 1'b0);
    check_table(k2);

    @(negedge clk);
    key_in = rand_key();
    key_req_valid = 1'b1;
    @(posedge clk);
    #1 key_req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chkb("t5_ready", key_req_ready, 1'b1);
    chkb("t5_busy", busy, 1'b0);
    chkb("t5_start", ks_start, 1'b0);
    chkb("t5_kr", keys_ready, 1'b0);
    chkb("t5_err", ks_err, 1'b0);
    chkk("t5_kskey", ks_key, 192'd0);
    chkd("t5_rd", rk_rd_data, 128'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    rd(4'd0, 128'd0);
    rd(4'd6, 128'd0);
    k2 = rand_key();
    request("t5b", k2, 13, 1'b1);
    check_table(k2);

`ifdef AES192_KS_REUSE_EN
    request("t6", k2, 0, 1'b0);
    chkb("t6_kr", keys_ready, 1'b1);
    check_table(k2);
`else
    request("t6", k2, 13, 1'b1);
    check_table(k2);
`endif
    k2 = rand_key();
    request("t6b", k2, 13, 1'b1);
    check_table(k2);

    for (int i = 0; i < 2; i++) begin
      k2 = rand_key();
      request($sformatf("rnd%0d", i), k2, 13, 1'b1);
      check_table(k2);
    end

    repeat (3) @(negedge clk);
    chki("rd_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
